// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic-array datapath: operand format and feed FSM encoding.
package dsp_sys_arr_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } single_float;

  typedef logic [1:0] feed_state_t;

  localparam feed_state_t FS_IDLE      = 2'd0;
  localparam feed_state_t FS_FEED      = 2'd1;
  localparam feed_state_t FS_WAIT_DONE = 2'd2;
  localparam feed_state_t FS_DONE      = 2'd3;

  localparam logic [15:0] WDOG_MAX = 16'hFFFF;

endpackage

// File: rtl/sys_arr_feed_ctrl_feed_lane.sv
// One edge lane: K-entry operand buffer, read pointer and registered valid/data toward the array.
module feed_lane
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned K  = 8,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [KW-1:0] wr_k_i,
  input  single_float   wr_dat_i,
  input  logic          clear_i,
  input  logic          elig_nxt_i,
  input  logic          ready_i,
  output logic          valid_o,
  output single_float   dat_o,
  output logic          fin_nxt_c_o
);

  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

  single_float   buf_q [K];
  logic [KW-1:0] k_q, k_d;
  logic          valid_q, valid_d;
  single_float   dat_q, dat_d;
  logic [IW-1:0] rd_idx;
  logic          wr_ok;

  assign wr_ok = wr_en_i && (wr_k_i < KW'(K));

  // Operand storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[IW'(wr_k_i)] <= wr_dat_i;
  end

  // A write landing in the start cycle is forwarded so the first beat sees it.
  always_comb begin
    k_d     = k_q;
    valid_d = 1'b0;
    dat_d   = '0;
    if (clear_i) begin
      k_d = '0;
    end else if (valid_q && ready_i) begin
      k_d = k_q + KW'(1);
    end
    rd_idx = IW'(k_d);
    if (elig_nxt_i && (k_d < KW'(K))) begin
      valid_d = 1'b1;
      dat_d   = (wr_ok && (wr_k_i == k_d)) ? wr_dat_i : buf_q[rd_idx];
    end
  end

  assign fin_nxt_c_o = (k_d == KW'(K));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      valid_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      k_q     <= k_d;
      valid_q <= valid_d;
      dat_q   <= dat_d;
    end
  end

  assign valid_o = valid_q;
  assign dat_o   = dat_q;

endmodule

// File: rtl/sys_arr_feed_ctrl.sv
// Edge scheduler for an N x N systolic array: skewed per-lane operand streaming and completion tracking.
// Optional watchdog on WAIT_DONE enabled by defining SYS_ARR_FEED_WDOG_EN.
module sys_arr_feed_ctrl
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 8,
  parameter int unsigned LW = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned KW = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  input  logic            ld_en_i,
  output logic            ld_ready_o,
  input  logic            ld_is_col_i,
  input  logic [LW-1:0]   ld_lane_i,
  input  logic [KW-1:0]   ld_k_i,
  input  single_float     ld_dat_i,
  output logic [N-1:0]    row_in_valid_o,
  input  logic [N-1:0]    row_in_ready_i,
  output logic [N*32-1:0] row_in_dat_o,
  output logic [N-1:0]    col_in_valid_o,
  input  logic [N-1:0]    col_in_ready_i,
  output logic [N*32-1:0] col_in_dat_o,
  input  logic [N*N-1:0]  comp_done_i,
  input  logic [N*N-1:0]  error_bit_i
);

  localparam int unsigned FW = $bits(single_float);

  feed_state_t   state_q, state_d;
  logic [LW-1:0] t_q, t_d;
  logic          busy_q, done_q, err_q, err_d, ld_ready_q;
  logic          start_ok, ld_ok;
  logic [N-1:0]  elig_nxt, row_fin, col_fin;
  single_float   row_dat [N];
  single_float   col_dat [N];
`ifdef SYS_ARR_FEED_WDOG_EN
  logic [15:0]   wdog_q, wdog_d;
`endif

  assign ld_ok = ld_en_i && (state_q == FS_IDLE);

  // Next-state, skew counter and sticky error.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    err_d    = err_q;
    start_ok = 1'b0;
    elig_nxt = '0;
`ifdef SYS_ARR_FEED_WDOG_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      FS_IDLE: begin
        if (start_i) begin
          state_d  = FS_FEED;
          t_d      = '0;
          start_ok = 1'b1;
        end
      end
      FS_FEED: begin
        if (t_q != LW'(N - 1)) t_d = t_q + LW'(1);
        if (&{row_fin, col_fin}) begin
          state_d = FS_WAIT_DONE;
`ifdef SYS_ARR_FEED_WDOG_EN
          wdog_d  = '0;
`endif
        end
      end
      FS_WAIT_DONE: begin
        if (&comp_done_i) begin
          state_d = FS_DONE;
        end
`ifdef SYS_ARR_FEED_WDOG_EN
        else if (wdog_q == WDOG_MAX) begin
          state_d = FS_DONE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
    if (((state_q == FS_FEED) || (state_q == FS_WAIT_DONE)) && (|error_bit_i)) err_d = 1'b1;
    if (start_ok) err_d = 1'b0;
    // Skew is purely time-based: lane i may issue once t has reached i.
    for (int unsigned i = 0; i < N; i++) begin
      elig_nxt[i] = (state_d == FS_FEED) && (t_d >= LW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      t_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b1;
`ifdef SYS_ARR_FEED_WDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      busy_q     <= (state_d == FS_FEED) || (state_d == FS_WAIT_DONE);
      done_q     <= (state_d == FS_DONE);
      err_q      <= err_d;
      ld_ready_q <= (state_d == FS_IDLE);
`ifdef SYS_ARR_FEED_WDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ld_ready_o = ld_ready_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    feed_lane #(.K(K), .KW(KW)) u_row (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (ld_ok && !ld_is_col_i && (ld_lane_i == LW'(g))),
      .wr_k_i      (ld_k_i),
      .wr_dat_i    (ld_dat_i),
      .clear_i     (start_ok),
      .elig_nxt_i  (elig_nxt[g]),
      .ready_i     (row_in_ready_i[g]),
      .valid_o     (row_in_valid_o[g]),
      .dat_o       (row_dat[g]),
      .fin_nxt_c_o (row_fin[g])
    );

    feed_lane #(.K(K), .KW(KW)) u_col (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (ld_ok && ld_is_col_i && (ld_lane_i == LW'(g))),
      .wr_k_i      (ld_k_i),
      .wr_dat_i    (ld_dat_i),
      .clear_i     (start_ok),
      .elig_nxt_i  (elig_nxt[g]),
      .ready_i     (col_in_ready_i[g]),
      .valid_o     (col_in_valid_o[g]),
      .dat_o       (col_dat[g]),
      .fin_nxt_c_o (col_fin[g])
    );

    assign row_in_dat_o[FW*g +: FW] = row_dat[g];
    assign col_in_dat_o[FW*g +: FW] = col_dat[g];
  end

endmodule

// File: doc/sys_arr_feed_ctrl.md
Name: sys_arr_feed_ctrl

Overview:
- Edge scheduler for an N x N systolic array of PEs.
- Holds one K-deep operand vector per row lane and per column lane, loaded through a write port while idle.
- On start, streams each lane into the array edge with diagonal skew (lane i starts i cycles late), using per-lane valid/ready handshakes.
- Waits for every PE's comp_done, then pulses done; aggregates PE error bits.

Parameters:
- N, 4, array dimension; number of row lanes and column lanes (N >= 1).
- K, 8, inner dimension; operands per lane (K >= 1).
- LW, $clog2(N) (min 1), lane index width.
- KW, $clog2(K+1), per-lane operand counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  begin feed; honoured only in IDLE.
- busy  out  1  high in FEED and WAIT_DONE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  sticky error flag; cleared on accepted start.
- ld_en  in  1  operand write strobe.
- ld_ready  out  1  high only in IDLE; writes are ignored otherwise.
- ld_is_col  in  1  0 selects the row buffer, 1 selects the column buffer.
- ld_lane  in  LW  lane index.
- ld_k  in  KW  operand index, 0..K-1; out-of-range writes are dropped.
- ld_dat  in  32  single_float operand.
- row_in_valid  out  N  per-row-lane valid toward the array's west edge.
- row_in_ready  in  N  per-row-lane ready from edge PEs.
- row_in_dat  out  N*32  per-row-lane operand, lane i at bits [32i+31:32i].
- col_in_valid  out  N  per-column-lane valid toward the north edge.
- col_in_ready  in  N  per-column-lane ready.
- col_in_dat  out  N*32  per-column-lane operand.
- comp_done  in  N*N  PE completion flags, level-sensitive.
- error_bit  in  N*N  PE error flags.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (CLK, nRST).
- Reset values: state=IDLE, busy=0, done=0, err=0, ld_ready=1, all valids=0, all dat=0, all lane counters and skew counter t cleared. Operand buffers are not reset.
- FSM states: IDLE, FEED, WAIT_DONE, DONE.
- IDLE -> FEED on start. Clears t, all k_row[i], all k_col[i], and err.
- FEED, skew counter: t increments each cycle and saturates at N-1. Lane i is eligible when t >= i, so lane 0 is eligible in the first FEED cycle.
- FEED, lane valid: row_in_valid[i] = eligible_i && k_row[i] < K, driven from registers. row_in_dat[i] = rowbuf[i][k_row[i]].
- FEED, lane advance: k_row[i] increments on valid && ready in the same cycle. Next data appears the following cycle, giving one operand per cycle under continuous ready.
- FEED, stall: while ready is low, valid and data are held stable. Valid never drops without a handshake.
- Column lanes are identical and independent, with their own counters.
- FEED -> WAIT_DONE when every k_row and k_col equals K; all valids are 0 in that cycle.
- WAIT_DONE -> DONE when &comp_done.
- DONE: done=1 for exactly one cycle, then IDLE.
- err: set when |error_bit in FEED or WAIT_DONE. It stays set through DONE and IDLE, and clears only when a new start is accepted.
- Boundaries:
  - start outside IDLE is ignored.
  - start and ld_en in the same IDLE cycle: the write lands, and FEED reads the new value.
  - N=1 gives no skew.
  - K=1 gives a single beat per lane.
  - A ready stall on lane 0 does not delay lane 1's eligibility; skew is time-based, not dependency-based.
  - comp_done already high on entering WAIT_DONE means DONE on the next cycle.
  - nRST asserted mid-FEED: valids drop immediately and the FSM returns to IDLE.

Optional Feature:
- SYS_ARR_FEED_WDOG_EN defined:
  - Adds a 16-bit watchdog counter, cleared on entering WAIT_DONE and incremented each WAIT_DONE cycle.
  - At 0xFFFF it sets err and forces DONE, so done still pulses.
- Undefined: WAIT_DONE waits indefinitely and no counter is built.

Decomposition:
- dsp_sys_arr_pkg gains:
  - the feed_state_t enum (IDLE, FEED, WAIT_DONE, DONE);
  - WDOG_MAX constant 16'hFFFF.
- Operands use the existing single_float type.
- One natural sub-module, feed_lane, instantiated 2N times. It contains:
  - the K-entry buffer and write port;
  - the k counter;
  - valid/data generation from an eligible input.
- The top level holds the FSM, skew counter, completion reduction and error reduction.

Test Plan:
- Ready tied high, N=4, K=8, rowbuf[i][k]=i*16+k: lane i valid in cycles i..i+7 after FEED entry. Data sequence i*16+0..7. WAIT_DONE entered at cycle 11.
- col_in_ready[2] low for 3 cycles mid-stream: col lane 2 holds valid and data constant, finishes 3 cycles late, other lanes unaffected.
- comp_done bits raised one at a time: FSM stays in WAIT_DONE until all 16 are high, then done pulses for exactly 1 cycle and busy falls.
- error_bit[5] pulsed once in FEED: err=1 through DONE and IDLE; next start clears it.
- nRST low mid-FEED: all valids 0 asynchronously. After release, ld_ready=1 and a fresh start completes normally.
- SYS_ARR_FEED_WDOG_EN defined, comp_done stuck low: done and err assert 65536 cycles after WAIT_DONE entry.
